mod_blkbuf_piso: RTL and testbench
==================================

// Module: mod_blkbuf_piso
// PURPOSE
//  Parametrised parallel-in/serial-out block buffer: stores whole AES state blocks (N_BYTES x DW)
//  from AddRoundKey in a DEPTH-slot circular queue and streams them byte-by-byte to the S-box ROM.
//  Adds back-pressure, occupancy flags, overflow detection, byte order mode and a synchronous flush.
//  Sits between the addRK stage and the SubBytes ROM in the round datapath.
// PARAMETERS
//  N_BYTES    16  bytes per block (>=2)
//  DW         8   bits per byte lane
//  DEPTH      2   block slots in the queue (>=1, any integer, pointers wrap modulo DEPTH)
//  MSB_FIRST  0   0: emit lane 0 first; 1: emit lane N_BYTES-1 first
// PORTS
//  clk        in   1                 rising-edge clock
//  reset      in   1                 asynchronous, active-high reset
//  clear      in   1                 synchronous flush of all stored blocks
//  i          in   [N_BYTES][DW]     parallel block from addRK
//  wr_en      in   1                 write request; block captured when wr_en && wr_ready
//  wr_ready   out  1                 queue can accept a block (= !full)
//  req_rom    in   1                 ROM consumes current byte this cycle
//  o          out  DW                current byte of head block (combinational from head slot + index)
//  o_valid    out  1                 o holds valid data (= !reg_empty)
//  o_last     out  1                 o is final byte of head block
//  reg_empty  out  1                 no block stored
//  full       out  1                 DEPTH blocks stored
//  overflow   out  1                 sticky: write attempted while full
// BEHAVIOUR
//  - Reset (async, any time incl. mid-stream): count=0, wr_ptr=rd_ptr=0, byte index=0, storage=0,
//    overflow=0 -> reg_empty=1, full=0, wr_ready=1, o_valid=0, o_last=0, o=0.
//  - clear=1 at clk edge: same end state as reset except storage contents need not be zeroed;
//    clear has priority over wr_en and req_rom in that cycle.
//  - Write: wr_en && !full -> slot[wr_ptr]<=i, wr_ptr<=wr_ptr+1 mod DEPTH, count+1. Data visible
//    on o the cycle after capture if queue was empty (1-cycle write-to-output latency).
//  - wr_en && full: block dropped, storage unchanged, overflow<=1 (held until reset/clear).
//  - Read: req_rom && o_valid -> byte index+1; at index N_BYTES-1 (o_last=1) index<=0,
//    rd_ptr<=rd_ptr+1 mod DEPTH, count-1. req_rom while empty: ignored, no state change.
//  - Lane selected = index (MSB_FIRST=0) or N_BYTES-1-index (MSB_FIRST=1). o=0 when empty.
//  - Simultaneous write and final-byte pop: if not full, both occur, count unchanged. If full,
//    write is dropped (wr_ready is registered-state based, no combinational ready-through-pop)
//    and overflow sets; pop proceeds.
//  - Writing never disturbs the head block being streamed (distinct slot unless DEPTH=1, where
//    write is only possible when empty).
//  - Counter widths: index $clog2(N_BYTES); pointers max(1,$clog2(DEPTH)); count $clog2(DEPTH+1).
//    All wrap explicitly at modulus, never by natural overflow.
//  - All state in one always_ff with nonblocking assignments; no $display in synthesised path.
// STRUCTURE
//  - Shared package aes_pkg: AES_NB_BYTES=16, typedef byte_t (logic[7:0]),
//    typedef block_t (byte_t[AES_NB_BYTES-1:0]); this block uses them as default N_BYTES/DW.
//  - One sub-module: mod_wrap_cnt #(MOD) (inc, clr -> value, wrap pulse), instanced for
//    byte index, wr_ptr and rd_ptr. Count, flags and storage stay in top.
// TESTING
//  1 Reset: assert reset mid-stream (index=7, count=2) -> next sample reg_empty=1, o_valid=0,
//    o=0, wr_ready=1, overflow=0; first write after release appears unaltered.
//  2 Single block: write i[k]=k+8'h10, then req_rom held 16 cycles -> o sequence 10..1F,
//    o_last only on 1F, reg_empty=1 the cycle after; MSB_FIRST=1 build -> 1F..10.
//  3 Fill/overflow (DEPTH=2): write A, B, C back-to-back without reads -> full=1 after B,
//    wr_ready=0, C dropped, overflow=1; stream out -> A then B bytes only.
//  4 Concurrent: one block stored, write B in same cycle as A's final byte pop -> count stays 1,
//    next o = B lane 0 with no bubble.
//  5 Full + final pop + write same cycle -> pop occurs, write dropped, overflow=1, count=DEPTH-1.
//  6 Empty read and clear: req_rom while empty -> no state change; clear with wr_en=1 and
//    req_rom=1 -> reg_empty=1, write not captured, overflow=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types.
//   AES_NB_BYTES : bytes in one AES state block
//   byte_t       : one byte lane
//   block_t      : one full state block, lane 0 in the low bits
//   ptr_w()      : width of a counter that counts 0..n-1 (at least 1 bit)
package aes_pkg;

   localparam int AES_NB_BYTES = 16;

   typedef logic [7:0] byte_t;
   typedef byte_t [AES_NB_BYTES-1:0] block_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_wrap_cnt.sv
// Modulo-MOD up counter used for byte index and queue pointers.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (value -> 0)
//   inc    in   advance by one this cycle
//   clr    in   synchronous return to 0, wins over inc
//   value  out  current count, 0..MOD-1
//   wrap   out  combinational: this inc takes value from MOD-1 back to 0
module mod_wrap_cnt
   import aes_pkg::*;
#(
   parameter  int MOD = 2,
   localparam int W   = ptr_w(MOD)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         wrap
);

   logic at_max;

   assign at_max = (value == W'(MOD - 1));
   assign wrap   = inc && at_max && !clr;

   // Wrap is an explicit compare against MOD-1 so non-power-of-two
   // moduli never run into the unused codes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= at_max ? '0 : value + W'(1);
      end
   end

endmodule

// File: rtl/mod_blkbuf_piso.sv
// Parallel-in / serial-out block buffer between the AddRoundKey stage and
// the SubBytes ROM. Whole blocks are queued in a DEPTH-slot circular
// buffer and streamed out one byte lane per ROM request.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous flush (beats wr_en and req_rom)
//   i            parallel block, lane k = i[k]
//   wr_en        write request          wr_ready  out: queue not full
//   req_rom      ROM takes o this cycle o         out: head byte (0 when empty)
//   o_valid      out: o holds data      o_last    out: o is last byte of block
//   reg_empty    out: no block stored   full      out: DEPTH blocks stored
//   overflow     out: sticky, a write arrived while full
//
// Handshakes: a block transfers on a clock edge where wr_en && wr_ready;
// a byte transfers on an edge where req_rom && o_valid. wr_ready depends
// only on registered occupancy, so a pop in the same cycle never opens
// room for a write. A write while full is dropped and sets overflow.
module mod_blkbuf_piso
   import aes_pkg::*;
#(
   parameter int N_BYTES   = AES_NB_BYTES,
   parameter int DW        = $bits(byte_t),
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic [N_BYTES-1:0][DW-1:0]  i,
   input  logic                        wr_en,
   output logic                        wr_ready,
   input  logic                        req_rom,
   output logic [DW-1:0]               o,
   output logic                        o_valid,
   output logic                        o_last,
   output logic                        reg_empty,
   output logic                        full,
   output logic                        overflow
);

   localparam int IW = ptr_w(N_BYTES);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [N_BYTES-1:0][DW-1:0] mem [DEPTH];
   logic [CW-1:0]              count;
   logic [IW-1:0]              idx;
   logic [IW-1:0]              lane;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic                       wr_fire;
   logic                       pop;
   logic                       pop_last;
   logic                       wr_wrap_unused;
   logic                       rd_wrap_unused;

   assign reg_empty = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign wr_ready  = !full;
   assign o_valid   = !reg_empty;

   assign wr_fire = wr_en && !full && !clear;
   assign pop     = req_rom && o_valid && !clear;

   // Byte index within the head block; its wrap pulse is the final-byte pop.
   mod_wrap_cnt #(.MOD(N_BYTES)) u_idx (
      .clk(clk), .reset(reset), .inc(pop), .clr(clear),
      .value(idx), .wrap(pop_last)
   );

   mod_wrap_cnt #(.MOD(DEPTH)) u_wr_ptr (
      .clk(clk), .reset(reset), .inc(wr_fire), .clr(clear),
      .value(wr_ptr), .wrap(wr_wrap_unused)
   );

   mod_wrap_cnt #(.MOD(DEPTH)) u_rd_ptr (
      .clk(clk), .reset(reset), .inc(pop_last), .clr(clear),
      .value(rd_ptr), .wrap(rd_wrap_unused)
   );

   assign lane   = MSB_FIRST ? (IW'(N_BYTES - 1) - idx) : idx;
   assign o      = o_valid ? mem[rd_ptr][lane] : '0;
   assign o_last = o_valid && (idx == IW'(N_BYTES - 1));

   // A write only lands in the head slot when the queue is empty, so the
   // block being streamed is never overwritten.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         overflow <= 1'b0;
         for (int d = 0; d < DEPTH; d++) begin
            mem[d] <= '0;
         end
      end else if (clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_fire) begin
            mem[wr_ptr] <= i;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         case ({wr_fire, pop_last})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_blkbuf_piso.sv
module tb_mod_blkbuf_piso;

   localparam int N     = 16;
   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int EW    = 2 * DW + 1;   // {last, lsb-first byte, msb-first byte}

   typedef logic [N-1:0][DW-1:0] blk_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic wr_en = 1'b0;
   logic req_rom = 1'b0;
   blk_t i_blk = '0;

   always #5 clk = ~clk;

   logic [DW-1:0] o_a, o_b;
   logic wr_ready_a, o_valid_a, o_last_a, reg_empty_a, full_a, overflow_a;
   logic wr_ready_b, o_valid_b, o_last_b, reg_empty_b, full_b, overflow_b;

   mod_blkbuf_piso #(.N_BYTES(N), .DW(DW), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .i(i_blk), .wr_en(wr_en),
      .wr_ready(wr_ready_a), .req_rom(req_rom), .o(o_a), .o_valid(o_valid_a),
      .o_last(o_last_a), .reg_empty(reg_empty_a), .full(full_a), .overflow(overflow_a)
   );

   mod_blkbuf_piso #(.N_BYTES(N), .DW(DW), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .i(i_blk), .wr_en(wr_en),
      .wr_ready(wr_ready_b), .req_rom(req_rom), .o(o_b), .o_valid(o_valid_b),
      .o_last(o_last_b), .reg_empty(reg_empty_b), .full(full_b), .overflow(overflow_b)
   );

   // ---------------- scoreboard ----------------
   // exp_q holds every byte still owed by the buffer, in output order.
   logic [EW-1:0] exp_q[$];
   bit exp_ovf = 1'b0;
   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : sb_proc
      logic [EW-1:0] head;
      bit has;
      bit full_e;
      int nblk;
      if (reset) begin
         exp_q.delete();
         exp_ovf = 1'b0;
      end
      has    = (exp_q.size() != 0);
      head   = has ? exp_q[0] : '0;
      nblk   = (exp_q.size() + N - 1) / N;
      full_e = (nblk == DEPTH);

      chk("flags_a", {o_valid_a, reg_empty_a, full_a, wr_ready_a, overflow_a},
          {has, !has, full_e, !full_e, exp_ovf});
      chk("flags_b", {o_valid_b, reg_empty_b, full_b, wr_ready_b, overflow_b},
          {has, !has, full_e, !full_e, exp_ovf});
      chk("o_lsb_first", o_a, head[2*DW-1:DW]);
      chk("o_msb_first", o_b, head[DW-1:0]);
      chk("o_last_a", o_last_a, head[2*DW]);
      chk("o_last_b", o_last_b, head[2*DW]);

      // Advance the reference with the inputs that the next edge will see.
      if (!reset) begin
         if (clear) begin
            exp_q.delete();
            exp_ovf = 1'b0;
         end else begin
            if (wr_en && full_e) exp_ovf = 1'b1;
            if (req_rom && has) void'(exp_q.pop_front());
            if (wr_en && !full_e) begin
               for (int k = 0; k < N; k++) begin
                  exp_q.push_back({(k == N - 1), i_blk[k], i_blk[N-1-k]});
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic blk_t mk(input logic [DW-1:0] base);
      blk_t b;
      for (int k = 0; k < N; k++) b[k] = base + DW'(k);
      return b;
   endfunction

   function automatic blk_t rnd_blk();
      blk_t b;
      for (int k = 0; k < N; k++) b[k] = DW'($urandom_range(0, 255));
      return b;
   endfunction

   task automatic cyc(input bit w, input blk_t b, input bit r, input bit c);
      @(posedge clk);
      #1;
      wr_en   = w;
      i_blk   = b;
      req_rom = r;
      clear   = c;
   endtask

   task automatic rd(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // single block, streamed with req_rom held
      cyc(1'b1, mk(8'h10), 1'b0, 1'b0);
      rd(16);
      idle(2);

      // fill past capacity, then drain: only A and B come out
      cyc(1'b1, mk(8'h40), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h60), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h80), 1'b0, 1'b0);
      idle(1);
      rd(32);
      idle(1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      idle(1);

      // write in the same cycle as the final byte pop of the only block
      cyc(1'b1, mk(8'hA0), 1'b0, 1'b0);
      rd(15);
      cyc(1'b1, mk(8'hC0), 1'b1, 1'b0);
      rd(16);
      idle(1);

      // full + final pop + write: write dropped, overflow set
      cyc(1'b1, mk(8'h20), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h30), 1'b0, 1'b0);
      rd(15);
      cyc(1'b1, mk(8'h50), 1'b1, 1'b0);
      rd(16);
      idle(1);

      // reads while empty, then clear against write/read with overflow set
      rd(3);
      cyc(1'b1, mk(8'h11), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h22), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h33), 1'b0, 1'b0);
      cyc(1'b1, mk(8'h70), 1'b1, 1'b1);
      idle(2);

      // asynchronous reset mid-stream (index 7, two blocks stored)
      cyc(1'b1, mk(8'h90), 1'b0, 1'b0);
      cyc(1'b1, mk(8'hB0), 1'b0, 1'b0);
      rd(7);
      @(posedge clk);
      #3;
      reset   = 1'b1;
      wr_en   = 1'b0;
      req_rom = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(1'b1, mk(8'hE0), 1'b0, 1'b0);
      rd(16);
      idle(1);

      // random traffic
      for (int t = 0; t < 600; t++) begin
         cyc($urandom_range(0, 2) != 0, rnd_blk(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 60) == 0);
      end
      rd(40);
      idle(2);
      @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
